// File: rtl/seg_2.sv
// Octave select and 7-segment octave display for the piano front panel.
// Keys blank/unblank the digit; up/down buttons step the octave once per press.
module seg_2 #(
    parameter int OCT_MIN = 1,
    parameter int OCT_MAX = 3,
    parameter int OCT_RST = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    input  logic e,
    input  logic f,
    input  logic g,
    input  logic up,
    input  logic down,
    output logic SEGa,
    output logic SEGb,
    output logic SEGc,
    output logic SEGd,
    output logic SEGe,
    output logic SEGg
);

    localparam logic [1:0] OCT_MIN_C = OCT_MIN[1:0];
    localparam logic [1:0] OCT_MAX_C = OCT_MAX[1:0];
    localparam logic [1:0] OCT_RST_C = OCT_RST[1:0];

    // Raw input bundle: bit 8 = up, bit 7 = down, bits 6..0 = keys g..a
    logic [8:0] rawIn;
    logic [8:0] syncS1;
    logic [8:0] syncS2;
    logic       upPrev;
    logic       downPrev;
    logic [1:0] octave;
    logic [1:0] octaveNext;
    logic [5:0] segReg;
    logic [5:0] segNext;
    logic       keyAny;
    logic       upPulse;
    logic       downPulse;

    assign rawIn = {up, down, g, f, e, d, c, b, a};

    always_ff @(posedge clk) begin
        if (rst) begin
            syncS1   <= '0;
            syncS2   <= '0;
            upPrev   <= 1'b0;
            downPrev <= 1'b0;
        end else begin
            syncS1   <= rawIn;
            syncS2   <= syncS1;
            upPrev   <= syncS2[8];
            downPrev <= syncS2[7];
        end
    end

    assign keyAny    = |syncS2[6:0];
    assign upPulse   = syncS2[8] & ~upPrev;
    assign downPulse = syncS2[7] & ~downPrev;

    // Simultaneous up and down presses cancel out
    always_comb begin
        octaveNext = octave;
        if (upPulse && !downPulse && octave < OCT_MAX_C) begin
            octaveNext = octave + 2'd1;
        end else if (downPulse && !upPulse && octave > OCT_MIN_C) begin
            octaveNext = octave - 2'd1;
        end
    end

    // Segment order {a,b,c,d,e,g}; unknown octave codes blank the digit
    always_comb begin
        segNext = 6'b000000;
        if (keyAny) begin
            case (octave)
                2'd1:    segNext = 6'b011000;
                2'd2:    segNext = 6'b110111;
                2'd3:    segNext = 6'b111101;
                default: segNext = 6'b000000;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            octave <= OCT_RST_C;
            segReg <= '0;
        end else begin
            octave <= octaveNext;
            segReg <= segNext;
        end
    end

    assign {SEGa, SEGb, SEGc, SEGd, SEGe, SEGg} = segReg;

endmodule

// File: tb/tb_seg_2.sv
// Self-checking bench for seg_2: directed front-panel scenarios plus random
// key/button/reset traffic compared against a delayed-input behavioural model.
module tb_seg_2;

    localparam int OCT_MIN = 1;
    localparam int OCT_MAX = 3;
    localparam int OCT_RST = 2;

    localparam logic [5:0] DIGIT1 = 6'b011000;
    localparam logic [5:0] DIGIT2 = 6'b110111;
    localparam logic [5:0] DIGIT3 = 6'b111101;

    logic       clk;
    logic       rst;
    logic [6:0] keys;
    logic       up;
    logic       down;
    logic       SEGa, SEGb, SEGc, SEGd, SEGe, SEGg;
    logic [5:0] segObs;

    int checks;
    int errors;

    // Model state: inputs as seen at previous edges (bit0 = last edge)
    logic [2:0] keyHist;
    logic [2:0] upHist;
    logic [2:0] downHist;
    int         modelOct;
    logic [5:0] expSeg;
    logic       modelValid;

    seg_2 #(.OCT_MIN(OCT_MIN), .OCT_MAX(OCT_MAX), .OCT_RST(OCT_RST)) dut (
        .clk(clk), .rst(rst),
        .a(keys[0]), .b(keys[1]), .c(keys[2]), .d(keys[3]),
        .e(keys[4]), .f(keys[5]), .g(keys[6]),
        .up(up), .down(down),
        .SEGa(SEGa), .SEGb(SEGb), .SEGc(SEGc), .SEGd(SEGd), .SEGe(SEGe), .SEGg(SEGg)
    );

    assign segObs = {SEGa, SEGb, SEGc, SEGd, SEGe, SEGg};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Standard abcdefg font for the digit, then drop segment f
    function automatic logic [5:0] shownDigit(input logic lit, input int oct);
        logic [6:0] font;
        case (oct)
            1:       font = 7'b0110000;
            2:       font = 7'b1101101;
            3:       font = 7'b1111001;
            default: font = 7'b0000000;
        endcase
        return lit ? {font[6:2], font[0]} : 6'b000000;
    endfunction

    function automatic int clampOct(input int v);
        if (v < OCT_MIN) return OCT_MIN;
        if (v > OCT_MAX) return OCT_MAX;
        return v;
    endfunction

    // Every input reaches the logic two edges late; a press is a 0->1 step of the delayed button
    always @(posedge clk) begin
        if (rst) begin
            modelOct   <= OCT_RST;
            expSeg     <= 6'b000000;
            keyHist    <= 3'b000;
            upHist     <= 3'b000;
            downHist   <= 3'b000;
            modelValid <= 1'b1;
        end else begin
            expSeg   <= shownDigit(keyHist[1], modelOct);
            modelOct <= clampOct(modelOct + int'(upHist[1] && !upHist[2])
                                          - int'(downHist[1] && !downHist[2]));
            keyHist  <= {keyHist[1:0], |keys};
            upHist   <= {upHist[1:0], up};
            downHist <= {downHist[1:0], down};
        end
    end

    task automatic checkOutput(input string tag, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (modelValid) checkOutput("model", segObs, expSeg);
    end

    task automatic applyStimulus(input logic [6:0] k, input logic u, input logic dn,
                                 input logic r, input int cycles);
        keys = k;
        up   = u;
        down = dn;
        rst  = r;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic pressButton(input logic [6:0] k, input logic u, input logic dn, input int holdCycles);
        applyStimulus(k, u, dn, 1'b0, holdCycles);
        applyStimulus(k, 1'b0, 1'b0, 1'b0, 5);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        modelValid = 1'b0;
        keys = '0; up = 1'b0; down = 1'b0; rst = 1'b1;
        @(negedge clk);
        applyStimulus(7'h00, 1'b0, 1'b0, 1'b1, 2);
        checkOutput("reset_blank", segObs, 6'b000000);

        applyStimulus(7'h01, 1'b0, 1'b0, 1'b0, 3);
        checkOutput("reset_digit2", segObs, DIGIT2);

        pressButton(7'h01, 1'b1, 1'b0, 10);
        checkOutput("up_to3", segObs, DIGIT3);
        pressButton(7'h01, 1'b1, 1'b0, 10);
        checkOutput("sat_max", segObs, DIGIT3);

        pressButton(7'h01, 1'b0, 1'b1, 10);
        checkOutput("down_to2", segObs, DIGIT2);
        pressButton(7'h01, 1'b0, 1'b1, 10);
        checkOutput("down_to1", segObs, DIGIT1);
        pressButton(7'h01, 1'b0, 1'b1, 10);
        checkOutput("sat_min", segObs, DIGIT1);

        pressButton(7'h01, 1'b1, 1'b0, 50);
        checkOutput("held_one_step", segObs, DIGIT2);

        applyStimulus(7'h00, 1'b0, 1'b0, 1'b0, 3);
        checkOutput("release_blank", segObs, 6'b000000);
        applyStimulus(7'h40, 1'b0, 1'b0, 1'b0, 3);
        checkOutput("retained_g", segObs, DIGIT2);

        pressButton(7'h40, 1'b1, 1'b1, 10);
        checkOutput("both_cancel", segObs, DIGIT2);

        for (int i = 0; i < 7; i++) begin
            logic [6:0] oneKey;
            oneKey = 7'(1 << i);
            applyStimulus(oneKey, i[0], ~i[0], 1'b0, 10);
            applyStimulus(oneKey, 1'b0, 1'b0, 1'b0, 40);
        end

        pressButton(7'h7F, 1'b1, 1'b0, 10);
        pressButton(7'h7F, 1'b1, 1'b0, 10);
        checkOutput("multi_key3", segObs, DIGIT3);
        applyStimulus(7'h04, 1'b1, 1'b0, 1'b1, 1);
        checkOutput("rst_midpress", segObs, 6'b000000);
        applyStimulus(7'h04, 1'b1, 1'b0, 1'b0, 3);
        checkOutput("rst_digit2", segObs, DIGIT2);
        applyStimulus(7'h04, 1'b1, 1'b0, 1'b0, 1);
        checkOutput("rst_held_up", segObs, DIGIT3);
        applyStimulus(7'h04, 1'b0, 1'b0, 1'b0, 5);

        for (int n = 0; n < 3000; n++) begin
            logic [6:0] rk;
            logic       ru, rd, rr;
            rk = ($urandom_range(0, 3) == 0) ? 7'h00 : 7'($urandom_range(0, 127));
            ru = ($urandom_range(0, 2) == 0);
            rd = ($urandom_range(0, 2) == 0);
            rr = ($urandom_range(0, 150) == 0);
            applyStimulus(rk, ru, rd, rr, $urandom_range(1, 6));
        end

        applyStimulus(7'h00, 1'b0, 1'b0, 1'b0, 4);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
